// File: rtl/multiword_add_seq_if.sv
// Purpose : request/result bundle for multiword_add_seq (operands in, sum and flags out).
// Latency : WORDS cycles from accepted start to the one-cycle done pulse.
// Backpressure: none. A start that arrives while busy is high is dropped, so the requester must wait for busy low.
// Ports   : start/a_in/b_in/c_in are the request; busy/done/sum_out/c_out/overflow are the status and result.
interface multiword_add_seq_if #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
);
    logic                     start;
    logic [WIDTH*WORDS-1:0]   a_in;
    logic [WIDTH*WORDS-1:0]   b_in;
    logic                     c_in;
    logic                     busy;
    logic                     done;
    logic [WIDTH*WORDS-1:0]   sum_out;
    logic                     c_out;
    logic                     overflow;

    // The requester owns the operands; the sequencer owns status and result.
    modport master (
        output start, a_in, b_in, c_in,
        input  busy, done, sum_out, c_out, overflow
    );

    modport slave (
        input  start, a_in, b_in, c_in,
        output busy, done, sum_out, c_out, overflow
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Purpose : adds two WIDTH*WORDS-bit operands one WIDTH-bit slice per cycle on a single RippleCarryAdder.
// Latency : WORDS cycles from accepted start to done. The block is occupied for WORDS+1 cycles.
// Backpressure: none. A start that arrives while busy is high (ADD or DONE) is dropped.
// Ports   : clk and reset (synchronous, active-high). bus is the slave side of multiword_add_seq_if.
//           Operands are latched on accept. sum_out, c_out and overflow hold until the next completion.
module multiword_add_seq #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    multiword_add_seq_if.slave bus
);
    localparam int N  = WIDTH * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [N-1:0]     res_q;
    logic [N-1:0]     res_d;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic             busy_q;
    logic             done_q;
    logic [N-1:0]     sum_q;
    logic             cout_q;
    logic             ov_q;

    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;
    logic [WIDTH-1:0] slice_sum;
    logic             slice_cout;

    always_comb begin
        slice_a = a_q[int'(k_q) * WIDTH +: WIDTH];
        slice_b = b_q[int'(k_q) * WIDTH +: WIDTH];
    end

    RippleCarryAdder #(.WIDTH(WIDTH)) u_slice (
        slice_a,
        slice_b,
        carry_q,
        slice_sum,
        slice_cout
    );

    // The working result with the current slice merged in. On the final slice,
    // this is the full sum that gets published. The last slice never has to
    // round-trip through res_q first.
    always_comb begin
        res_d = res_q;
        res_d[int'(k_q) * WIDTH +: WIDTH] = slice_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a_in;
                        b_q     <= bus.b_in;
                        carry_q <= bus.c_in;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    res_q   <= res_d;
                    carry_q <= slice_cout;
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        sum_q   <= res_d;
                        cout_q  <= slice_cout;
                        // Signed overflow: the operands agree in sign but the sum does not.
                        ov_q    <= (a_q[N-1] == b_q[N-1]) && (res_d[N-1] != a_q[N-1]);
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // A start seen here is deliberately dropped. The next accept can only happen from IDLE.
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum_out  = sum_q;
    assign bus.c_out    = cout_q;
    assign bus.overflow = ov_q;
endmodule

// Purpose : WIDTH-bit ripple-carry adder slice, port order (a, b, c_in, sum, c_out).
// Latency : purely combinational.
// Backpressure: none.
module RippleCarryAdder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    logic [WIDTH:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c_out = c[WIDTH];
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;
    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multiword_add_seq_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         cout;
        logic         ov;
    } vec_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [N-1:0] prev_sum;
    vec_t         vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: a plain wide addition, with signed overflow from the sign rule.
    function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        vec_t       v;
        logic [N:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.sum  = full[N-1:0];
        v.cout = full[N];
        v.ov   = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
        return v;
    endfunction

    // Starts one operation at E0, then checks busy and done at every cycle up to E(WORDS+1).
    // With hold set, start stays high carrying 0xAAAA/0x5555 for the whole operation.
    // Otherwise the operand inputs are scrambled after acceptance.
    task automatic do_op(input vec_t v, input bit hold, input string name);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = v.a;
        bus.b_in  = v.b;
        bus.c_in  = v.cin;
        for (int n = 0; n <= WORDS + 1; n++) begin
            @(negedge clk);
            check({name, "_busy"}, 32'(bus.busy), 32'(n <= WORDS));
            check({name, "_done"}, 32'(bus.done), 32'(n == WORDS));
            if (n == 0) check({name, "_sum_held"}, 32'(bus.sum_out), 32'(prev_sum));
            if (n == WORDS) begin
                check({name, "_sum"},  32'(bus.sum_out),  32'(v.sum));
                check({name, "_cout"}, 32'(bus.c_out),    32'(v.cout));
                check({name, "_ov"},   32'(bus.overflow), 32'(v.ov));
            end
            if (hold) begin
                bus.start = 1'b1;
                bus.a_in  = 16'hAAAA;
                bus.b_in  = 16'h5555;
                bus.c_in  = 1'b0;
            end else begin
                bus.start = 1'b0;
                bus.a_in  = N'($urandom);
                bus.b_in  = N'($urandom);
                bus.c_in  = 1'($urandom);
            end
        end
        prev_sum = v.sum;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   done_cnt;
        bit   seen;

        vecs[0] = '{16'h1234, 16'h0005, 1'b0, 16'h1239, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        // Reset for two cycles.
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.c_in  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy),     32'd0);
        check("rst_done", 32'(bus.done),     32'd0);
        check("rst_sum",  32'(bus.sum_out),  32'd0);
        check("rst_cout", 32'(bus.c_out),    32'd0);
        check("rst_ov",   32'(bus.overflow), 32'd0);
        reset    = 1'b0;
        prev_sum = '0;

        // Directed vectors.
        for (int i = 0; i < 5; i++) do_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Start held high during the operation, with new operands. Only one done is expected.
        // The held start must be accepted no earlier than E6.
        v = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};
        do_op(v, 1'b1, "hold");
        @(negedge clk);
        check("hold_accept_e6", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < WORDS + 2 && !seen; n++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("hold_second_done", 32'(seen), 32'd1);
        check("hold_second_sum", 32'(bus.sum_out), 32'h0000FFFF);
        @(negedge clk);
        check("hold_second_idle", 32'(bus.busy), 32'd0);
        prev_sum = 16'hFFFF;

        // Reset at E2, aborting the operation. A start sampled alongside reset must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 16'h1111;
        bus.b_in  = 16'h2222;
        bus.c_in  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_busy_e0", 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy),    32'd0);
        check("abort_done", 32'(bus.done),    32'd0);
        check("abort_sum",  32'(bus.sum_out), 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("abort_start_ignored", 32'(bus.busy), 32'd0);
        done_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        prev_sum = '0;
        v = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
        do_op(v, 1'b0, "after_abort");

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            v = model(N'($urandom), N'($urandom), 1'($urandom));
            do_op(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencer that adds two WIDTH*WORDS-bit operands over WORDS clock cycles on a single WIDTH-bit RippleCarryAdder slice. Each cycle it feeds one operand slice, least significant first, into the adder and registers the adder's c_out as the c_in for the next slice. It sits directly upstream of, and wraps, one RippleCarryAdder #(WIDTH) instance, so the team can add wide operands without instantiating a wide carry chain.

## Interface
- WIDTH, 4, bit width of the RippleCarryAdder slice; must be >= 1
- WORDS, 4, number of slices per operand; must be >= 2
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a_in  in  WIDTH*WORDS  operand A, unsigned or two's complement
- b_in  in  WIDTH*WORDS  operand B
- c_in  in  1  carry into bit 0
- busy  out  1  high in ADD and DONE
- done  out  1  one-cycle pulse; result valid
- sum_out  out  WIDTH*WORDS  result, (a_in + b_in + c_in) mod 2^(WIDTH*WORDS)
- c_out  out  1  carry out of the MSB
- overflow  out  1  signed overflow: sign(a) == sign(b) and sign(sum) != sign(a)

## Operation
- One RippleCarryAdder #(WIDTH) is instantiated with port order (a, b, c_in, sum, c_out). It is the only adder in the block; there is no other arithmetic apart from the slice counter.
- State machine:
  - IDLE --(start)--> ADD
  - ADD --(k == WORDS-1)--> DONE
  - DONE --> IDLE, unconditionally
  - reset returns to IDLE from any state.
- On start accepted in IDLE:
  - latch a_in, b_in and c_in into internal registers
  - slice counter k := 0
  - carry register := c_in
- In ADD, slice k:
  - adder a = A[k*WIDTH +: WIDTH], adder b = B[k*WIDTH +: WIDTH], adder c_in = carry register
  - at the edge: write the adder sum into the working result slice k, write the adder c_out into the carry register, then k := k+1
- On the edge leaving ADD, the last slice completes and these outputs load:
  - sum_out := full working result
  - c_out := final carry
  - overflow := computed from the latched MSBs of A and B and the final sum MSB
- sum_out, c_out and overflow hold their values until the next operation completes. They do not change on start.
- start while busy is ignored, including in the DONE cycle. The input operands are not sampled after acceptance, so changing a_in, b_in or c_in mid-operation has no effect.
- Width rules:
  - operands wrap modulo 2^(WIDTH*WORDS)
  - c_out is the unsigned carry
  - overflow is the signed condition
  - both are reported independently.

## Timing
- Reset values: busy=0, done=0, sum_out=0, c_out=0, overflow=0, state=IDLE, k=0, carry register=0, latched operands=0.
- Let E0 be the edge at which start is sampled high in IDLE.
  - busy is high from after E0 through the cycle following E(WORDS+1) exclusive, i.e. busy is high for WORDS+1 cycles.
  - Slice k is computed combinationally in the cycle after E(k) and registered at E(k+1), for k = 0..WORDS-1.
  - done is high for exactly one cycle, between E(WORDS) and E(WORDS+1). sum_out, c_out and overflow are valid from E(WORDS) onward.
- Latency is WORDS cycles from start to done. An operation occupies WORDS+1 cycles; the earliest next accept is at E(WORDS+2), so with start held high the accept period is WORDS+2 cycles.
- Reset mid-operation:
  - at the reset edge, all state and outputs return to reset values
  - done does not pulse for the aborted operation
  - start sampled in the same cycle as reset is ignored.

## Test plan
Defaults: WIDTH=4, WORDS=4.
- Reset: assert reset for 2 cycles -> busy=0, done=0, sum_out=0x0000, c_out=0, overflow=0.
- Basic add: a=0x1234, b=0x0005, c_in=0, start pulse at E0 -> done only between E4 and E5; sum_out=0x1239, c_out=0, overflow=0; busy high from E0 to E5.
- Carry across all slices: a=0xFFFF, b=0x0001, c_in=0 -> sum_out=0x0000, c_out=1, overflow=0. Second operation a=0x0000, b=0x0000, c_in=1 -> sum_out=0x0001, c_out=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum_out=0x8000, c_out=0, overflow=1. a=0x8000, b=0x8000 -> sum_out=0x0000, c_out=1, overflow=1.
- Ignored start and input changes: start with a=0x0F0F, b=0x0101; assert start with a=0xAAAA, b=0x5555 at E1..E4 and drive new a_in/b_in -> single done; sum_out=0x1010. Next accept no earlier than E6.
- Reset mid-op: start a=0x1111, b=0x2222, then assert reset at E2 -> busy=0 after E2, no done pulse, sum_out=0x0000. The next start with a=0x0001, b=0x0002 returns sum_out=0x0003 after 4 cycles.
